// File: rtl/commit_queue.sv
// Commit queue between writeback and an in-order commit consumer.
// Filters reset bubbles, buffers retired instructions and halts after a trap drains.
module commit_queue #(
   parameter int          DEPTH       = 4,
   parameter logic [63:0] PC_START    = 64'h8000_0000,
   parameter logic [6:0]  TRAP_OPCODE = 7'h6b
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] wb_pc,
   input  logic [31:0] wb_inst,
   input  logic        wb_rf_we,
   input  logic [4:0]  wb_rf_wnum,
   input  logic [63:0] wb_rf_wdata,
   input  logic [63:0] wb_a0,
   input  logic        cmt_ready,
   output logic        cmt_valid,
   output logic [63:0] cmt_pc,
   output logic [31:0] cmt_inst,
   output logic        cmt_wen,
   output logic [7:0]  cmt_wdest,
   output logic [63:0] cmt_wdata,
   output logic        trap_valid,
   output logic [7:0]  trap_code,
   output logic [63:0] trap_pc,
   output logic [63:0] cycle_cnt,
   output logic [63:0] instr_cnt,
   output logic        wb_stall,
   output logic        overflow
);

   localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

   state_t        r_state, w_state_next;
   logic [63:0]   r_pc_mem    [DEPTH];
   logic [31:0]   r_inst_mem  [DEPTH];
   logic          r_wen_mem   [DEPTH];
   logic [4:0]    r_wdest_mem [DEPTH];
   logic [63:0]   r_wdata_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr, r_wr_ptr;
   logic [AW:0]   r_count, w_count_next;

   logic w_slot_valid, w_full, w_pop, w_push, w_drop, w_trap_push;
   logic w_unused_a0;

   assign w_unused_a0  = ^wb_a0[63:8];
   assign w_slot_valid = (wb_pc != PC_START) || (wb_inst != '0);
   assign w_full       = (r_count == FULL_CNT);
   assign w_pop        = cmt_valid && cmt_ready;
   assign w_push       = w_slot_valid && (r_state == RUN) && (!w_full || w_pop);
   assign w_drop       = w_slot_valid && (r_state == RUN) && w_full && !w_pop;
   assign w_trap_push  = w_push && (wb_inst[6:0] == TRAP_OPCODE);
   assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

   // Head entry comes straight out of storage; no output register stage.
   assign cmt_valid  = (r_count != '0);
   assign cmt_pc     = r_pc_mem[r_rd_ptr];
   assign cmt_inst   = r_inst_mem[r_rd_ptr];
   assign cmt_wen    = r_wen_mem[r_rd_ptr];
   assign cmt_wdest  = {3'b000, r_wdest_mem[r_rd_ptr]};
   assign cmt_wdata  = r_wdata_mem[r_rd_ptr];
   assign wb_stall   = w_full && !cmt_ready;
   assign trap_valid = (r_state == HALT);

   // NOTE: storage is cleared on reset so the head fields read zero after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_pc_mem[i]    <= '0;
            r_inst_mem[i]  <= '0;
            r_wen_mem[i]   <= 1'b0;
            r_wdest_mem[i] <= '0;
            r_wdata_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_pc_mem[r_wr_ptr]    <= wb_pc;
         r_inst_mem[r_wr_ptr]  <= wb_inst;
         r_wen_mem[r_wr_ptr]   <= wb_rf_we && (wb_rf_wnum != '0);
         r_wdest_mem[r_wr_ptr] <= wb_rf_wnum;
         r_wdata_mem[r_wr_ptr] <= wb_rf_wdata;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= RUN;
         r_rd_ptr  <= '0;
         r_wr_ptr  <= '0;
         r_count   <= '0;
         overflow  <= 1'b0;
         trap_code <= '0;
         trap_pc   <= '0;
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + AW'(1);
            instr_cnt <= instr_cnt + 64'd1;
         end
         if (w_drop) overflow <= 1'b1;
         if (w_trap_push) begin
            trap_code <= wb_a0[7:0];
            trap_pc   <= wb_pc;
         end
         if (r_state != HALT) cycle_cnt <= cycle_cnt + 64'd1;
      end
   end

   // NOTE: default assigned first so the next-state logic never infers a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         RUN:     if (w_trap_push) w_state_next = DRAIN;
         DRAIN:   if (w_count_next == '0) w_state_next = HALT;
         HALT:    w_state_next = HALT;
         default: w_state_next = RUN;
      endcase
   end

endmodule
